// File: rtl/dma.sv
// dma: width-converting ping-pong bridge between an 8-bit CPU port and a 4-bit MEM port.
//   mode=1: CPU bytes are filled into buffer A/B, drained to MEM as nibbles (low nibble first).
//   mode=0: MEM nibbles are packed into bytes (first nibble -> [3:0]), drained to CPU as bytes.
// Ports:
//   clk, resetn                          clock, async active-low reset
//   mode                                 1 = cpu->mem, 0 = mem->cpu
//   cpu_to_dma_valid/cpu_data_out        CPU source beat, accepted with cpu_to_dma_enable
//   dma_to_cpu_valid/cpu_data_in         CPU sink beat, taken with dma_to_cpu_enable
//   mem_to_dma_valid/mem_data_out        MEM source beat, accepted with mem_to_dma_enable
//   dma_to_mem_valid/mem_data_in         MEM sink beat, taken with dma_to_mem_enable
module dma #(
    parameter int unsigned BUF_BYTES = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       mode,
    input  logic       cpu_to_dma_valid,
    input  logic [7:0] cpu_data_out,
    output logic       cpu_to_dma_enable,
    input  logic       dma_to_cpu_enable,
    output logic       dma_to_cpu_valid,
    output logic [7:0] cpu_data_in,
    input  logic       mem_to_dma_valid,
    input  logic [3:0] mem_data_out,
    output logic       mem_to_dma_enable,
    input  logic       dma_to_mem_enable,
    output logic       dma_to_mem_valid,
    output logic [3:0] mem_data_in
);

    localparam int unsigned BIDX_W    = $clog2(BUF_BYTES);
    localparam int unsigned NIDX_W    = BIDX_W + 1;
    localparam int unsigned BYTE_LAST = BUF_BYTES - 1;
    localparam int unsigned NIB_LAST  = 2 * BUF_BYTES - 1;

    logic              mode_q,   mode_d;
    logic              fill_q,   fill_d;
    logic              drain_q,  drain_d;
    logic [1:0]        full_q,   full_d;
    logic [NIDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [NIDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [7:0]        buf_q [2][BUF_BYTES];
    logic [7:0]        buf_d [2][BUF_BYTES];

    logic              active;
    logic              src_en;
    logic              snk_vld;
    logic              src_fire;
    logic              snk_fire;
    logic              src_last;
    logic              snk_last;
    logic [BIDX_W-1:0] rd_bsel;
    logic [7:0]        rd_byte;
    logic [3:0]        rd_nib;

    // Handshakes are only live out of reset and while mode matches its registered copy,
    // so nothing moves on a flush edge and all outputs read 0 during reset.
    assign active  = resetn && (mode == mode_q);
    assign src_en  = active && !full_q[fill_q];
    assign snk_vld = active && full_q[drain_q];

    // Sink data: mode=1 reads nibbles (index = byte*2 + half), mode=0 reads whole bytes.
    assign rd_bsel = mode ? rd_idx_q[NIDX_W-1:1] : rd_idx_q[BIDX_W-1:0];
    assign rd_byte = buf_q[drain_q][rd_bsel];
    assign rd_nib  = rd_idx_q[0] ? rd_byte[7:4] : rd_byte[3:0];

    assign cpu_to_dma_enable = src_en && mode;
    assign mem_to_dma_enable = src_en && !mode;
    assign dma_to_mem_valid  = snk_vld && mode;
    assign dma_to_cpu_valid  = snk_vld && !mode;
    assign mem_data_in       = (active && mode)  ? rd_nib  : 4'h0;
    assign cpu_data_in       = (active && !mode) ? rd_byte : 8'h00;

    assign src_fire = mode ? (cpu_to_dma_valid && cpu_to_dma_enable)
                           : (mem_to_dma_valid && mem_to_dma_enable);
    assign snk_fire = mode ? (dma_to_mem_valid && dma_to_mem_enable)
                           : (dma_to_cpu_valid && dma_to_cpu_enable);
    assign src_last = mode ? (wr_idx_q == NIDX_W'(BYTE_LAST)) : (wr_idx_q == NIDX_W'(NIB_LAST));
    assign snk_last = mode ? (rd_idx_q == NIDX_W'(NIB_LAST))  : (rd_idx_q == NIDX_W'(BYTE_LAST));

    // Next-state: flush on mode change, otherwise independent fill and drain updates.
    always_comb begin
        mode_d   = mode_q;
        fill_d   = fill_q;
        drain_d  = drain_q;
        full_d   = full_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        buf_d    = buf_q;

        if (mode != mode_q) begin
            mode_d   = mode;
            fill_d   = 1'b0;
            drain_d  = 1'b0;
            full_d   = 2'b00;
            wr_idx_d = '0;
            rd_idx_d = '0;
        end else begin
            if (src_fire) begin
                if (mode) begin
                    buf_d[fill_q][wr_idx_q[BIDX_W-1:0]] = cpu_data_out;
                end else if (wr_idx_q[0]) begin
                    buf_d[fill_q][wr_idx_q[NIDX_W-1:1]][7:4] = mem_data_out;
                end else begin
                    buf_d[fill_q][wr_idx_q[NIDX_W-1:1]][3:0] = mem_data_out;
                end
                if (src_last) begin
                    full_d[fill_q] = 1'b1;
                    fill_d         = ~fill_q;
                    wr_idx_d       = '0;
                end else begin
                    wr_idx_d = wr_idx_q + NIDX_W'(1);
                end
            end
            // Fill targets a non-full buffer and drain a full one, so the bits never collide.
            if (snk_fire) begin
                if (snk_last) begin
                    full_d[drain_q] = 1'b0;
                    drain_d         = ~drain_q;
                    rd_idx_d        = '0;
                end else begin
                    rd_idx_d = rd_idx_q + NIDX_W'(1);
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mode_q   <= 1'b0;
            fill_q   <= 1'b0;
            drain_q  <= 1'b0;
            full_q   <= 2'b00;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < int'(BUF_BYTES); i++) begin
                    buf_q[b][i] <= 8'h00;
                end
            end
        end else begin
            mode_q   <= mode_d;
            fill_q   <= fill_d;
            drain_q  <= drain_d;
            full_q   <= full_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            buf_q    <= buf_d;
        end
    end

endmodule

// File: tb/tb_dma.sv
// tb_dma: randomized scoreboard bench for dma. Source beats seen on the bus are turned into the
// expected sink stream (byte -> low nibble, high nibble; nibble pair -> byte) and queued; a
// monitor pops and compares on every sink beat.
module tb_dma;

    logic       clk = 1'b0;
    logic       resetn;
    logic       mode;
    logic       cpu_to_dma_valid;
    logic [7:0] cpu_data_out;
    logic       cpu_to_dma_enable;
    logic       dma_to_cpu_enable;
    logic       dma_to_cpu_valid;
    logic [7:0] cpu_data_in;
    logic       mem_to_dma_valid;
    logic [3:0] mem_data_out;
    logic       mem_to_dma_enable;
    logic       dma_to_mem_enable;
    logic       dma_to_mem_valid;
    logic [3:0] mem_data_in;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] sb[$];
    logic [3:0] lo_nib;
    bit         have_lo = 1'b0;
    int         sink_pct = 0;

    dma #(.BUF_BYTES(4)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .mode             (mode),
        .cpu_to_dma_valid (cpu_to_dma_valid),
        .cpu_data_out     (cpu_data_out),
        .cpu_to_dma_enable(cpu_to_dma_enable),
        .dma_to_cpu_enable(dma_to_cpu_enable),
        .dma_to_cpu_valid (dma_to_cpu_valid),
        .cpu_data_in      (cpu_data_in),
        .mem_to_dma_valid (mem_to_dma_valid),
        .mem_data_out     (mem_data_out),
        .mem_to_dma_enable(mem_to_dma_enable),
        .dma_to_mem_enable(dma_to_mem_enable),
        .dma_to_mem_valid (dma_to_mem_valid),
        .mem_data_in      (mem_data_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: sampled on negedge, where the values equal what the next posedge will see.
    initial begin
        forever begin
            @(negedge clk);
            if (cpu_to_dma_valid && cpu_to_dma_enable) begin
                sb.push_back({4'h0, cpu_data_out[3:0]});
                sb.push_back({4'h0, cpu_data_out[7:4]});
            end
            if (mem_to_dma_valid && mem_to_dma_enable) begin
                if (have_lo) begin
                    sb.push_back({mem_data_out, lo_nib});
                    have_lo = 1'b0;
                end else begin
                    lo_nib  = mem_data_out;
                    have_lo = 1'b1;
                end
            end
            if (dma_to_mem_valid && dma_to_mem_enable) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL mem_unexpected actual=%0h required=none", mem_data_in);
                end else begin
                    check("mem_nibble", 32'(mem_data_in), 32'(sb.pop_front()));
                end
            end
            if (dma_to_cpu_valid && dma_to_cpu_enable) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL cpu_unexpected actual=%0h required=none", cpu_data_in);
                end else begin
                    check("cpu_byte", 32'(cpu_data_in), 32'(sb.pop_front()));
                end
            end
        end
    end

    // Sink ready generators.
    initial begin
        dma_to_mem_enable = 1'b0;
        dma_to_cpu_enable = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            dma_to_mem_enable = (int'($urandom_range(99)) < sink_pct);
            dma_to_cpu_enable = (int'($urandom_range(99)) < sink_pct);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sink(input int pct);
        sink_pct = pct;
        step();
        step();
    endtask

    // Offer one source beat until it is accepted; returns just after the accepting edge.
    task automatic send_beat(input bit is_cpu, input logic [7:0] d, input int pct);
        bit acc   = 1'b0;
        int guard = 0;
        while (!acc) begin
            if (is_cpu) begin
                cpu_to_dma_valid = (int'($urandom_range(99)) < pct);
                cpu_data_out     = d;
            end else begin
                mem_to_dma_valid = (int'($urandom_range(99)) < pct);
                mem_data_out     = d[3:0];
            end
            @(negedge clk);
            acc = is_cpu ? (cpu_to_dma_valid && cpu_to_dma_enable)
                         : (mem_to_dma_valid && mem_to_dma_enable);
            step();
            guard++;
            if (!acc && guard > 5000) begin
                total++;
                bad++;
                $display("FAIL send_timeout actual=stalled required=accepted");
                acc = 1'b1;
            end
        end
        cpu_to_dma_valid = 1'b0;
        mem_to_dma_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int g = 0;
        while (sb.size() != 0 && g < 8000) begin
            step();
            g++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic flush_model();
        sb.delete();
        have_lo = 1'b0;
    endtask

    initial begin
        resetn           = 1'b0;
        mode             = 1'b1;
        cpu_to_dma_valid = 1'b0;
        cpu_data_out     = 8'h00;
        mem_to_dma_valid = 1'b0;
        mem_data_out     = 4'h0;
        #12;
        check("rst_cpu_en",  32'(cpu_to_dma_enable), 32'd0);
        check("rst_mem_en",  32'(mem_to_dma_enable), 32'd0);
        check("rst_mem_vld", 32'(dma_to_mem_valid),  32'd0);
        check("rst_cpu_vld", 32'(dma_to_cpu_valid),  32'd0);
        check("rst_cpu_dat", 32'(cpu_data_in),       32'd0);
        check("rst_mem_dat", 32'(mem_data_in),       32'd0);

        step();
        resetn = 1'b1;
        step();
        check("rel_cpu_en",  32'(cpu_to_dma_enable), 32'd1);
        check("rel_mem_vld", 32'(dma_to_mem_valid),  32'd0);
        check("rel_mem_en",  32'(mem_to_dma_enable), 32'd0);

        // mode=1 directed: valid rises right after the 4th byte.
        send_beat(1'b1, 8'h21, 100);
        send_beat(1'b1, 8'h43, 100);
        send_beat(1'b1, 8'h65, 100);
        check("lat_before", 32'(dma_to_mem_valid), 32'd0);
        send_beat(1'b1, 8'h87, 100);
        check("lat_after",  32'(dma_to_mem_valid), 32'd1);
        check("m1_cpu_dat", 32'(cpu_data_in), 32'd0);
        set_sink(100);
        wait_drain();

        // Back-pressure: both buffers full with MEM stalled.
        set_sink(0);
        for (int i = 0; i < 8; i++) send_beat(1'b1, 8'($urandom), 100);
        check("bp_cpu_en",  32'(cpu_to_dma_enable), 32'd0);
        check("bp_mem_vld", 32'(dma_to_mem_valid),  32'd1);
        set_sink(100);
        wait_drain();

        // mode=0 directed: nibbles 1..8 -> bytes 21,43,65,87.
        mode = 1'b0;
        step();
        step();
        check("m0_mem_en",  32'(mem_to_dma_enable), 32'd1);
        check("m0_cpu_en",  32'(cpu_to_dma_enable), 32'd0);
        check("m0_mem_vld", 32'(dma_to_mem_valid),  32'd0);
        for (int i = 1; i <= 8; i++) send_beat(1'b0, 8'(i), 100);
        wait_drain();

        // Random traffic, mode=0 then mode=1.
        set_sink(50);
        for (int i = 0; i < 1000; i++) send_beat(1'b0, 8'($urandom), 50);
        wait_drain();
        mode = 1'b1;
        step();
        step();
        for (int i = 0; i < 1000; i++) send_beat(1'b1, 8'($urandom), 50);
        wait_drain();

        // Flush on mode toggle with 2 bytes buffered.
        set_sink(0);
        send_beat(1'b1, 8'hA5, 100);
        send_beat(1'b1, 8'h5A, 100);
        mode = 1'b0;
        flush_model();
        step();
        check("fl_mem_vld", 32'(dma_to_mem_valid),  32'd0);
        check("fl_cpu_vld", 32'(dma_to_cpu_valid),  32'd0);
        check("fl_mem_en",  32'(mem_to_dma_enable), 32'd1);
        mode = 1'b1;
        step();
        check("fl_cpu_en",  32'(cpu_to_dma_enable), 32'd1);
        for (int i = 0; i < 3; i++) send_beat(1'b1, 8'($urandom), 100);
        check("fl_clean3",  32'(dma_to_mem_valid), 32'd0);
        send_beat(1'b1, 8'hC3, 100);
        check("fl_clean4",  32'(dma_to_mem_valid), 32'd1);
        set_sink(100);
        wait_drain();

        // Reset mid-transfer discards everything.
        set_sink(0);
        send_beat(1'b1, 8'h11, 100);
        send_beat(1'b1, 8'h22, 100);
        resetn = 1'b0;
        flush_model();
        #1;
        check("mr_cpu_en",  32'(cpu_to_dma_enable), 32'd0);
        check("mr_mem_vld", 32'(dma_to_mem_valid),  32'd0);
        step();
        resetn = 1'b1;
        step();
        for (int i = 0; i < 4; i++) send_beat(1'b1, 8'($urandom), 100);
        check("mr_full4",   32'(dma_to_mem_valid), 32'd1);
        set_sink(100);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
